column_buffer_array: RTL and testbench

Multi-column successor to the single-column parallel buffer. It holds `NUM_COL` independent circular column buffers, each `2^ADDR_WIDTH` deep. Each column has its own write and read pointers, occupancy count, full/empty flags and sticky overflow/underflow errors. The block sits between the activation fetch path and the PE array; it optionally lets a column re-read a marked region across filter passes.

---
 rtl/column_buffer_array.sv | 139 +++++++++++++
 tb/tb_column_buffer_array.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/column_buffer_array.sv
// column_buffer_array: NUM_COL independent circular column buffers.
// Optional COLBUF_REWIND_EN adds mark/rewind re-read of a retained region.
module column_buffer_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_COL    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mode,
    input  logic [NUM_COL-1:0]                wr_req,
    input  logic [NUM_COL*DATA_WIDTH-1:0]     wr_data,
    input  logic [NUM_COL-1:0]                rd_req,
`ifdef COLBUF_REWIND_EN
    input  logic [NUM_COL-1:0]                mark,
    input  logic [NUM_COL-1:0]                rewind,
`endif
    output logic [NUM_COL*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_COL-1:0]                rd_valid,
    output logic [NUM_COL-1:0]                full,
    output logic [NUM_COL-1:0]                empty,
    output logic [NUM_COL*(ADDR_WIDTH+1)-1:0] count,
    output logic [NUM_COL-1:0]                ovf_err,
    output logic [NUM_COL-1:0]                udf_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
        logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         count_q, count_d;
        logic [CW-1:0]         held_w;
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  valid_q, ovf_q, udf_q;
        logic                  full_w, empty_w;
        logic                  wr_acc, rd_acc, rew_w;

`ifdef COLBUF_REWIND_EN
        logic [CW-1:0]         held_q, held_d;
        logic [ADDR_WIDTH-1:0] base_q, base_d;

        assign rew_w  = rewind[c];
        assign held_w = held_q;

        // Retained-entry bookkeeping; rewind wins over mark.
        always_comb begin
            held_d = held_q + CW'(rd_acc);
            base_d = base_q;
            if (rew_w) begin
                held_d = '0;
            end else if (mark[c]) begin
                // A read in the mark cycle is already past the new base.
                held_d = CW'(rd_acc);
                base_d = rd_ptr_q;
            end
        end

        // Rewind state registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                held_q <= '0;
                base_q <= '0;
            end else begin
                held_q <= held_d;
                base_q <= base_d;
            end
        end
`else
        assign rew_w  = 1'b0;
        assign held_w = '0;
`endif

        assign full_w  = (count_q + held_w) == DEPTH_C;
        assign empty_w = (count_q == '0);
        assign wr_acc  = wr_req[c] & ~full_w;
        assign rd_acc  = rd_req[c] & ~empty_w & ~rew_w;

        // Next-state pointers, occupancy and read data.
        always_comb begin
            wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
`ifdef COLBUF_REWIND_EN
            if (rew_w) begin
                rd_ptr_d = base_q;
                count_d  = count_q + held_q + CW'(wr_acc);
            end
`endif
            if (rd_acc) begin
                data_d = mem_q[rd_ptr_q];
            end else if (mode) begin
                data_d = '0;
            end else begin
                data_d = data_q;
            end
        end

        // Storage array; contents need no reset since count gates reads.
        always_ff @(posedge clk) begin
            if (!reset && wr_acc) begin
                mem_q[wr_ptr_q] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Column control registers and sticky errors.
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                data_q   <= '0;
                valid_q  <= 1'b0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                data_q   <= data_d;
                valid_q  <= rd_acc;
                ovf_q    <= ovf_q | (wr_req[c] & full_w);
                udf_q    <= udf_q | (rd_req[c] & empty_w & ~rew_w);
            end
        end

        assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign count[c*CW +: CW] = count_q;
        assign rd_valid[c] = valid_q;
        assign full[c]     = full_w;
        assign empty[c]    = empty_w;
        assign ovf_err[c]  = ovf_q;
        assign udf_err[c]  = udf_q;
    end

endmodule

// File: tb/tb_column_buffer_array.sv
// tb_column_buffer_array: directed vector bench, depth-4 columns.
// Rewind checks are compiled only when COLBUF_REWIND_EN is defined.
module tb_column_buffer_array;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NC = 4;
    localparam int CW = AW + 1;

    logic              clk;
    logic              reset;
    logic              mode;
    logic [NC-1:0]     wr_req;
    logic [NC*DW-1:0]  wr_data;
    logic [NC-1:0]     rd_req;
    logic [NC*DW-1:0]  rd_data;
    logic [NC-1:0]     rd_valid;
    logic [NC-1:0]     full;
    logic [NC-1:0]     empty;
    logic [NC*CW-1:0]  count;
    logic [NC-1:0]     ovf_err;
    logic [NC-1:0]     udf_err;
`ifdef COLBUF_REWIND_EN
    logic [NC-1:0]     mark;
    logic [NC-1:0]     rewind;
`endif

    int total = 0;
    int bad   = 0;

    column_buffer_array #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_COL   (NC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .rd_req  (rd_req),
`ifdef COLBUF_REWIND_EN
        .mark    (mark),
        .rewind  (rewind),
`endif
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wr;
        logic [31:0] wd;
        logic [3:0]  rd;
        logic        md;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [3:0]  ee;
        logic [3:0]  ef;
        logic [11:0] ec;
        logic [3:0]  eo;
        logic [3:0]  eu;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        logic [3:0] wr, logic [31:0] wd, logic [3:0] rd, logic md,
        logic [3:0] ev, logic [31:0] ed, logic [3:0] ee, logic [3:0] ef,
        logic [11:0] ec, logic [3:0] eo, logic [3:0] eu);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.md = md;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ef = ef;
        v.ec = ec; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] w, input logic [31:0] wd,
                        input logic [3:0] r, input logic m);
        wr_req  = w;
        wr_data = wd;
        rd_req  = r;
        mode    = m;
        @(posedge clk);
        #1;
        wr_req = '0;
        rd_req = '0;
    endtask

    initial begin
        reset   = 1'b1;
        mode    = 1'b0;
        wr_req  = '0;
        wr_data = '0;
        rd_req  = '0;
`ifdef COLBUF_REWIND_EN
        mark    = '0;
        rewind  = '0;
`endif
        tbl[0]  = mk(4'h1, 32'h11, 4'h0, 0, 4'h0, 32'h0, 4'hE, 4'h0, 12'h001, 4'h0, 4'h0);
        tbl[1]  = mk(4'h1, 32'h12, 4'h0, 0, 4'h0, 32'h0, 4'hE, 4'h0, 12'h002, 4'h0, 4'h0);
        tbl[2]  = mk(4'h1, 32'h13, 4'h0, 0, 4'h0, 32'h0, 4'hE, 4'h0, 12'h003, 4'h0, 4'h0);
        tbl[3]  = mk(4'h1, 32'h14, 4'h0, 0, 4'h0, 32'h0, 4'hE, 4'h1, 12'h004, 4'h0, 4'h0);
        tbl[4]  = mk(4'h0, 32'h0, 4'h1, 0, 4'h1, 32'h11, 4'hE, 4'h0, 12'h003, 4'h0, 4'h0);
        tbl[5]  = mk(4'h0, 32'h0, 4'h1, 0, 4'h1, 32'h12, 4'hE, 4'h0, 12'h002, 4'h0, 4'h0);
        tbl[6]  = mk(4'h0, 32'h0, 4'h1, 0, 4'h1, 32'h13, 4'hE, 4'h0, 12'h001, 4'h0, 4'h0);
        tbl[7]  = mk(4'h0, 32'h0, 4'h1, 0, 4'h1, 32'h14, 4'hF, 4'h0, 12'h000, 4'h0, 4'h0);
        tbl[8]  = mk(4'h0, 32'h0, 4'h0, 0, 4'h0, 32'h14, 4'hF, 4'h0, 12'h000, 4'h0, 4'h0);
        tbl[9]  = mk(4'h2, 32'h2100, 4'h0, 0, 4'h0, 32'h14, 4'hD, 4'h0, 12'h008, 4'h0, 4'h0);
        tbl[10] = mk(4'h2, 32'h2200, 4'h0, 0, 4'h0, 32'h14, 4'hD, 4'h0, 12'h010, 4'h0, 4'h0);
        tbl[11] = mk(4'h2, 32'h2300, 4'h0, 0, 4'h0, 32'h14, 4'hD, 4'h0, 12'h018, 4'h0, 4'h0);
        tbl[12] = mk(4'h2, 32'h2400, 4'h0, 0, 4'h0, 32'h14, 4'hD, 4'h2, 12'h020, 4'h0, 4'h0);
        tbl[13] = mk(4'h2, 32'h2500, 4'h0, 0, 4'h0, 32'h14, 4'hD, 4'h2, 12'h020, 4'h2, 4'h0);
        tbl[14] = mk(4'h0, 32'h0, 4'h2, 0, 4'h2, 32'h2114, 4'hD, 4'h0, 12'h018, 4'h2, 4'h0);
        tbl[15] = mk(4'h0, 32'h0, 4'h2, 0, 4'h2, 32'h2214, 4'hD, 4'h0, 12'h010, 4'h2, 4'h0);
        tbl[16] = mk(4'h0, 32'h0, 4'h2, 0, 4'h2, 32'h2314, 4'hD, 4'h0, 12'h008, 4'h2, 4'h0);
        tbl[17] = mk(4'h0, 32'h0, 4'h2, 0, 4'h2, 32'h2414, 4'hF, 4'h0, 12'h000, 4'h2, 4'h0);
        tbl[18] = mk(4'h0, 32'h0, 4'h4, 0, 4'h0, 32'h2414, 4'hF, 4'h0, 12'h000, 4'h2, 4'h4);
        tbl[19] = mk(4'h0, 32'h0, 4'h4, 1, 4'h0, 32'h0, 4'hF, 4'h0, 12'h000, 4'h2, 4'h4);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", 32'(rd_valid), 32'h0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_err", {ovf_err, udf_err}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].md);
            chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_data", i), rd_data, tbl[i].ed);
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].ee));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].ef));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ec));
            chk($sformatf("v%0d_ovf", i), 32'(ovf_err), 32'(tbl[i].eo));
            chk($sformatf("v%0d_udf", i), 32'(udf_err), 32'(tbl[i].eu));
        end

        // Column 3: hold count at 2 with concurrent write+read across wraps.
        step(4'h8, 32'h30000000, 4'h0, 0);
        step(4'h8, 32'h31000000, 4'h0, 0);
        chk("c3_pre_count", 32'(count[11:9]), 32'd2);
        for (int i = 0; i < 10; i++) begin
            step(4'h8, {8'(8'h32 + i), 24'h0}, 4'h8, 0);
            chk($sformatf("c3_%0d_valid", i), 32'(rd_valid), 32'h8);
            chk($sformatf("c3_%0d_data", i), 32'(rd_data[31:24]), 32'(8'h30 + i));
            chk($sformatf("c3_%0d_count", i), 32'(count[11:9]), 32'd2);
        end
        chk("c3_empty", 32'(empty), 32'h7);

        // Reset mid-stream with requests present in the reset cycle.
        step(4'h1, 32'h55, 4'h0, 0);
        step(4'h1, 32'h66, 4'h1, 0);
        chk("pre_rst_valid", 32'(rd_valid), 32'h1);
        reset = 1'b1;
        step(4'hF, 32'h77777777, 4'hF, 0);
        reset = 1'b0;
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_empty", 32'(empty), 32'hF);
        chk("mid_rst_valid", 32'(rd_valid), 32'h0);
        chk("mid_rst_data", rd_data, 32'h0);
        chk("mid_rst_err", {ovf_err, udf_err}, 32'h0);
        step(4'h0, 32'h0, 4'h0, 0);
        chk("post_rst_empty", 32'(empty), 32'hF);
        chk("post_rst_count", 32'(count), 32'h0);

`ifdef COLBUF_REWIND_EN
        step(4'h1, 32'hA0, 4'h0, 0);
        step(4'h1, 32'hA1, 4'h0, 0);
        step(4'h1, 32'hA2, 4'h0, 0);
        mark = 4'h1;
        step(4'h0, 32'h0, 4'h0, 0);
        mark = 4'h0;
        step(4'h0, 32'h0, 4'h1, 0);
        chk("rw_rd0", 32'(rd_data[7:0]), 32'hA0);
        step(4'h0, 32'h0, 4'h1, 0);
        chk("rw_rd1", 32'(rd_data[7:0]), 32'hA1);
        chk("rw_held_nfull", 32'(full[0]), 32'h0);
        step(4'h1, 32'hA3, 4'h0, 0);
        chk("rw_held_full", 32'(full[0]), 32'h1);
        chk("rw_cnt2", 32'(count[2:0]), 32'd2);
        rewind = 4'h1;
        step(4'h0, 32'h0, 4'h1, 0);
        rewind = 4'h0;
        chk("rw_cnt4", 32'(count[2:0]), 32'd4);
        chk("rw_valid", 32'(rd_valid), 32'h0);
        chk("rw_udf", 32'(udf_err), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 32'h0, 4'h1, 0);
            chk($sformatf("rw_re%0d", i), 32'(rd_data[7:0]), 32'(8'hA0 + i));
            chk($sformatf("rw_rv%0d", i), 32'(rd_valid), 32'h1);
        end
        chk("rw_empty", 32'(empty[0]), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
